decode_sequencer: RTL and testbench
===================================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter DEPTH, default 2, number of issue-buffer entries; legal values are 2 and 4.
REQ-002 Parameter STALL_CNT_W, default 16, width of the serialization-stall counter.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 flush_i  in  1  kill every in-flight instruction in this block.
REQ-006 fetch_valid_i  in  1  fetch offers an instruction.
REQ-007 fetch_instr_i  in  32  offered instruction.
REQ-008 fetch_pc_i  in  64  PC of the offered instruction.
REQ-009 fetch_ready_o  out  1  block accepts the offer this cycle.
REQ-010 dec_instr_o  out  32  instruction driven to the decoder; equals fetch_instr_i combinationally.
REQ-011 dec_pc_o  out  64  PC driven to the decoder; equals fetch_pc_i combinationally.
REQ-012 dec_serialize_i  in  1  decoder flags CSR, FENCE or FENCE.I.
REQ-013 dec_cf_i  in  1  decoder is_control_flow_instr flag.
REQ-014 sb_empty_i  in  1  scoreboard holds no uncommitted instruction.
REQ-015 issue_valid_o  out  1  buffer head is valid.
REQ-016 issue_ready_i  in  1  scoreboard accepts the head.
REQ-017 issue_instr_o / issue_pc_o / issue_cf_o  out  32/64/1  buffer-head fields.
REQ-018 stall_cnt_o  out  STALL_CNT_W  cycles spent in DRAIN or SERIAL.

Function
REQ-019 Accept occurs when fetch_valid_i && fetch_ready_o; pop occurs when issue_valid_o && issue_ready_i.
REQ-020 In RUN, fetch_ready_o = !full && !flush_i.
- An accept with !dec_serialize_i pushes {instr, pc, dec_cf_i} into the buffer.
- An accept with dec_serialize_i writes the entry to the hold register instead, and the state moves to DRAIN.
REQ-021 Latency: an instruction accepted in cycle N shall appear at the buffer head no earlier than N+1; there is no fetch-to-issue bypass.
REQ-022 In DRAIN, fetch_ready_o = 0.
- When the buffer is empty and sb_empty_i = 1, the hold entry is pushed and the state moves to SERIAL.
REQ-023 In SERIAL, fetch_ready_o = 0.
- Leave to RUN once the serializing entry has been popped, and then sb_empty_i = 1 is sampled in a cycle strictly after that pop.
REQ-024 The buffer is FIFO ordered with wrap-around pointers and a count.
- Pop and push may occur in the same cycle; count is unchanged when they do.
- No push occurs when the buffer is full.
REQ-025 flush_i has priority over every other event in its cycle:
- buffer count and hold-valid are cleared;
- state goes to RUN;
- any same-cycle push or pop is discarded;
- issue_valid_o = 0 from the next cycle.
REQ-026 stall_cnt_o increments by 1 every cycle the state is DRAIN or SERIAL, saturates at all-ones, and is not cleared by flush_i.
REQ-027 issue_valid_o = (count != 0); the issue_* fields are don't-care while issue_valid_o = 0.

Reset
REQ-028 With reset = 1 at a rising edge:
- state goes to RUN;
- count, pointers, hold-valid, the post-pop flag and stall_cnt_o go to 0.
REQ-029 During reset and in the first cycle after it, issue_valid_o = 0; fetch_ready_o = 0 while reset = 1.
REQ-030 Reset applied mid-DRAIN or mid-SERIAL discards the hold entry; the serializing instruction is not issued.

Structure
REQ-031 Package decode_seq_pkg holds:
- the state enum {RUN, DRAIN, SERIAL};
- the issue_entry_t struct {instr, pc, cf};
- the default DEPTH constant.
REQ-032 The buffer is one sub-module, decode_fifo, parameterized on DEPTH and issue_entry_t; the FSM, hold register and counter live in decode_sequencer.

Verification
REQ-033 Back-to-back ADDI stream, issue_ready_i = 1:
- accept in cycle N, issue in N+1, fetch_ready_o held at 1;
- at DEPTH = 2 the buffer never fills.
REQ-034 issue_ready_i = 0 with 3 offers:
- 2 accepted, then fetch_ready_o = 0;
- issue_ready_i = 1 for one cycle pops pc 0x1000 and re-opens fetch_ready_o the next cycle.
REQ-035 CSRRW at pc 0x2000 with 1 entry buffered and sb_empty_i = 0:
- state goes DRAIN and fetch_ready_o = 0;
- CSRRW is pushed only after the buffer is empty and sb_empty_i = 1;
- RUN resumes one cycle after the pop when sb_empty_i = 1;
- stall_cnt_o equals the cycles spent in DRAIN plus SERIAL.
REQ-036 flush_i asserted with 2 buffered entries in the same cycle as an offer and a pop:
- next cycle issue_valid_o = 0 and the state is RUN;
- the offer is not accepted.
REQ-037 Branch BEQ: issue_cf_o = 1 at the buffer head.
REQ-038 stall_cnt_o preset near all-ones via a long DRAIN saturates and does not wrap.
REQ-039 Reset asserted in SERIAL: next cycle state = RUN, issue_valid_o = 0, stall_cnt_o = 0.

Source files
------------

// File: rtl/decode_sequencer_pkg.sv
// Shared types for the decode sequencer: FSM states, issue-buffer entry, default depth.
package decode_seq_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SERIAL = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        cf;
  } issue_entry_t;

  localparam int DEPTH_DEFAULT = 2;

endpackage

// File: rtl/decode_sequencer_if.sv
// Fetch, decoder and issue handshakes of the decode sequencer.
// The slave modport is the sequencer's view.
interface decode_sequencer_if;
  logic        fetch_valid_i;
  logic [31:0] fetch_instr_i;
  logic [63:0] fetch_pc_i;
  logic        fetch_ready_o;
  logic [31:0] dec_instr_o;
  logic [63:0] dec_pc_o;
  logic        dec_serialize_i;
  logic        dec_cf_i;
  logic        sb_empty_i;
  logic        issue_valid_o;
  logic        issue_ready_i;
  logic [31:0] issue_instr_o;
  logic [63:0] issue_pc_o;
  logic        issue_cf_o;

  modport slave (
    input  fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_serialize_i, dec_cf_i,
           sb_empty_i, issue_ready_i,
    output fetch_ready_o, dec_instr_o, dec_pc_o, issue_valid_o, issue_instr_o,
           issue_pc_o, issue_cf_o
  );

  modport master (
    output fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_serialize_i, dec_cf_i,
           sb_empty_i, issue_ready_i,
    input  fetch_ready_o, dec_instr_o, dec_pc_o, issue_valid_o, issue_instr_o,
           issue_pc_o, issue_cf_o
  );
endinterface

// File: rtl/decode_sequencer_fifo.sv
// Issue buffer: DEPTH-entry FIFO with wrap-around pointers and an occupancy count.
// Flush and reset both empty it and win over a same-cycle push or pop.
module decode_fifo
  import decode_seq_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEFAULT,
  parameter type entry_t = issue_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push_en, pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/decode_sequencer.sv
// Sits between fetch and issue: buffers decoded instructions and serializes
// CSR/FENCE by draining the buffer and scoreboard around them.
module decode_sequencer
  import decode_seq_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  decode_sequencer_if.slave      bus,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);
  seq_state_e   state, state_nxt;
  issue_entry_t fetch_entry, fifo_din, head, hold_q;
  logic         hold_vld, hold_vld_nxt, hold_load;
  logic         post_pop, post_pop_nxt;
  logic         full, empty, accept, pop, push;

  assign bus.dec_instr_o = bus.fetch_instr_i;
  assign bus.dec_pc_o    = bus.fetch_pc_i;

  assign fetch_entry = '{instr: bus.fetch_instr_i, pc: bus.fetch_pc_i, cf: bus.dec_cf_i};

  assign bus.fetch_ready_o = (state == RUN) && !full && !flush_i && !reset;
  assign accept            = bus.fetch_valid_i && bus.fetch_ready_o;
  assign bus.issue_valid_o = !empty && !reset;
  assign pop               = bus.issue_valid_o && bus.issue_ready_i;

  assign bus.issue_instr_o = head.instr;
  assign bus.issue_pc_o    = head.pc;
  assign bus.issue_cf_o    = head.cf;

  always_comb begin
    state_nxt    = state;
    push         = 1'b0;
    fifo_din     = fetch_entry;
    hold_load    = 1'b0;
    hold_vld_nxt = hold_vld;
    post_pop_nxt = post_pop;
    unique case (state)
      RUN: begin
        if (accept) begin
          if (bus.dec_serialize_i) begin
            hold_load    = 1'b1;
            hold_vld_nxt = 1'b1;
            state_nxt    = DRAIN;
          end else begin
            push = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (hold_vld && empty && bus.sb_empty_i) begin
          push         = 1'b1;
          fifo_din     = hold_q;
          hold_vld_nxt = 1'b0;
          state_nxt    = SERIAL;
        end
      end
      SERIAL: begin
        // The buffer holds only the serializing entry here, so any pop is it;
        // sb_empty_i only counts once that pop has already happened.
        if (post_pop && bus.sb_empty_i) begin
          post_pop_nxt = 1'b0;
          state_nxt    = RUN;
        end else if (pop) begin
          post_pop_nxt = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
    if (flush_i) begin
      state_nxt    = RUN;
      push         = 1'b0;
      hold_load    = 1'b0;
      hold_vld_nxt = 1'b0;
      post_pop_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      hold_vld <= 1'b0;
      post_pop <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_vld <= hold_vld_nxt;
      post_pop <= post_pop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (hold_load) hold_q <= fetch_entry;
  end

  // Survives flush on purpose: it measures serialization cost over the run.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt_o <= '0;
    else if (state != RUN && stall_cnt_o != '1)
      stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
  end

  decode_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (issue_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush_i),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_decode_sequencer.sv
// Scoreboard bench for decode_sequencer: accepted offers queue expected issue
// entries, pops are compared in order; directed cycles check handshake timing.
module tb_decode_sequencer;
  import decode_seq_pkg::*;

  localparam int SCW = 5;
  localparam logic [31:0] ADDI  = 32'h0010_8093;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] CSRRW = 32'h3402_9073;

  logic clk = 1'b0;
  logic reset, flush;
  logic [SCW-1:0] stall;
  int n_vec = 0;
  int n_err = 0;
  issue_entry_t exp_q[$];
  issue_entry_t e;

  decode_sequencer_if bus();

  decode_sequencer #(.DEPTH(2), .STALL_CNT_W(SCW)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (flush),
    .bus         (bus),
    .stall_cnt_o (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] instr,
                       input logic ser, input logic cf);
    bus.fetch_valid_i   = v;
    bus.fetch_pc_i      = pc;
    bus.fetch_instr_i   = instr;
    bus.dec_serialize_i = ser;
    bus.dec_cf_i        = cf;
  endtask

  // Scoreboard: push on accept, compare on pop; flush/reset empty it.
  always @(negedge clk) begin
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (bus.issue_valid_o && bus.issue_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pop", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("iss_pc", bus.issue_pc_o, e.pc);
          chk("iss_instr", {32'd0, bus.issue_instr_o}, {32'd0, e.instr});
          chk("iss_cf", {63'd0, bus.issue_cf_o}, {63'd0, e.cf});
        end
      end
      if (bus.fetch_valid_i && bus.fetch_ready_o)
        exp_q.push_back('{instr: bus.fetch_instr_i, pc: bus.fetch_pc_i, cf: bus.dec_cf_i});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drive(1'b1, 64'h0, ADDI, 1'b0, 1'b0);
    bus.sb_empty_i    = 1'b1;
    bus.issue_ready_i = 1'b0;

    // Reset: no handshakes while asserted or in the first cycle after.
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", bus.fetch_ready_o, 0);
      chk("rst_ivalid", bus.issue_valid_o, 0);
    end
    step();
    reset = 1'b0;
    drive(1'b0, 64'h0, ADDI, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_ivalid", bus.issue_valid_o, 0);
    chk("post_rst_stall", stall, 0);
    chk("post_rst_ready", bus.fetch_ready_o, 1);
    chk("dec_pc_pass", bus.dec_pc_o, 64'h0);
    step();

    // Back-to-back ADDI stream with the scoreboard always ready.
    bus.issue_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 64'h100 + 64'(4 * i), ADDI, 1'b0, 1'b0);
      @(negedge clk);
      chk("b2b_ready", bus.fetch_ready_o, 1);
      chk("b2b_dec_instr", {32'd0, bus.dec_instr_o}, {32'd0, ADDI});
      if (i == 0) begin
        chk("b2b_nobypass", bus.issue_valid_o, 0);
      end else begin
        chk("b2b_ivalid", bus.issue_valid_o, 1);
        chk("b2b_head_pc", bus.issue_pc_o, 64'h100 + 64'(4 * (i - 1)));
      end
      step();
    end
    drive(1'b0, 64'h0, ADDI, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_last_pc", bus.issue_pc_o, 64'h114);
    step();
    @(negedge clk);
    chk("b2b_empty", bus.issue_valid_o, 0);
    step();

    // Backpressure: two accepted, third blocked until a pop frees a slot.
    bus.issue_ready_i = 1'b0;
    drive(1'b1, 64'h1000, ADDI, 1'b0, 1'b0);
    @(negedge clk); chk("bp_ready0", bus.fetch_ready_o, 1); step();
    drive(1'b1, 64'h1004, ADDI, 1'b0, 1'b0);
    @(negedge clk); chk("bp_ready1", bus.fetch_ready_o, 1); step();
    drive(1'b1, 64'h1008, ADDI, 1'b0, 1'b0);
    @(negedge clk); chk("bp_full_ready", bus.fetch_ready_o, 0); step();
    bus.issue_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_pop_ready", bus.fetch_ready_o, 0);
    chk("bp_pop_pc", bus.issue_pc_o, 64'h1000);
    step();
    bus.issue_ready_i = 1'b0;
    @(negedge clk);
    chk("bp_reopen", bus.fetch_ready_o, 1);
    chk("bp_head_pc", bus.issue_pc_o, 64'h1004);
    step();
    drive(1'b0, 64'h0, ADDI, 1'b0, 1'b0);
    bus.issue_ready_i = 1'b1;
    repeat (2) step();
    @(negedge clk); chk("bp_drained", bus.issue_valid_o, 0); step();

    // Serializing CSRRW behind a buffered BEQ.
    bus.issue_ready_i = 1'b0;
    bus.sb_empty_i    = 1'b0;
    drive(1'b1, 64'h1ffc, BEQ, 1'b0, 1'b1);
    @(negedge clk); chk("ser_beq_ready", bus.fetch_ready_o, 1); step();
    drive(1'b1, 64'h2000, CSRRW, 1'b1, 1'b0);
    @(negedge clk);
    chk("ser_csr_ready", bus.fetch_ready_o, 1);
    chk("beq_cf", bus.issue_cf_o, 1);
    chk("beq_ivalid", bus.issue_valid_o, 1);
    step();
    drive(1'b1, 64'h2004, ADDI, 1'b0, 1'b0);
    @(negedge clk); chk("drain_ready", bus.fetch_ready_o, 0); step();
    bus.issue_ready_i = 1'b1;
    @(negedge clk);
    chk("drain_ready2", bus.fetch_ready_o, 0);
    chk("drain_head_pc", bus.issue_pc_o, 64'h1ffc);
    step();
    bus.issue_ready_i = 1'b0;
    @(negedge clk);
    chk("drain_hold_sb", bus.issue_valid_o, 0);
    chk("drain_ready3", bus.fetch_ready_o, 0);
    step();
    bus.sb_empty_i = 1'b1;
    @(negedge clk); chk("drain_push_cycle", bus.issue_valid_o, 0); step();
    bus.sb_empty_i = 1'b0;
    @(negedge clk);
    chk("serial_ivalid", bus.issue_valid_o, 1);
    chk("serial_pc", bus.issue_pc_o, 64'h2000);
    chk("serial_ready", bus.fetch_ready_o, 0);
    step();
    bus.issue_ready_i = 1'b1;
    bus.sb_empty_i    = 1'b1;
    @(negedge clk); chk("serial_pop_ready", bus.fetch_ready_o, 0); step();
    bus.issue_ready_i = 1'b0;
    bus.sb_empty_i    = 1'b0;
    @(negedge clk);
    chk("serial_wait_ready", bus.fetch_ready_o, 0);
    chk("serial_popped", bus.issue_valid_o, 0);
    step();
    bus.sb_empty_i = 1'b1;
    @(negedge clk); chk("serial_exit_ready", bus.fetch_ready_o, 0); step();
    @(negedge clk);
    chk("resume_ready", bus.fetch_ready_o, 1);
    chk("stall_cnt", stall, 8);
    step();
    drive(1'b0, 64'h0, ADDI, 1'b0, 1'b0);
    bus.issue_ready_i = 1'b1;
    @(negedge clk); chk("resume_pc", bus.issue_pc_o, 64'h2004); step();
    @(negedge clk); chk("resume_empty", bus.issue_valid_o, 0); step();

    // Flush with two buffered entries plus same-cycle offer and pop.
    bus.issue_ready_i = 1'b0;
    drive(1'b1, 64'h3000, ADDI, 1'b0, 1'b0);
    @(negedge clk); step();
    drive(1'b1, 64'h3004, ADDI, 1'b0, 1'b0);
    @(negedge clk); step();
    flush = 1'b1;
    bus.issue_ready_i = 1'b1;
    drive(1'b1, 64'h3008, ADDI, 1'b0, 1'b0);
    @(negedge clk); chk("flush_ready", bus.fetch_ready_o, 0); step();
    flush = 1'b0;
    drive(1'b0, 64'h0, ADDI, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush_ivalid", bus.issue_valid_o, 0);
    chk("flush_run", bus.fetch_ready_o, 1);
    chk("flush_stall", stall, 8);
    step();
    flush = 1'b1;
    drive(1'b1, 64'h3100, ADDI, 1'b0, 1'b0);
    @(negedge clk); chk("flush_ready_empty", bus.fetch_ready_o, 0); step();
    flush = 1'b0;
    drive(1'b0, 64'h0, ADDI, 1'b0, 1'b0);
    @(negedge clk); chk("flush_no_accept", bus.issue_valid_o, 0); step();

    // Long DRAIN drives the stall counter into saturation; flush keeps it.
    bus.sb_empty_i    = 1'b0;
    bus.issue_ready_i = 1'b0;
    drive(1'b1, 64'h5000, CSRRW, 1'b1, 1'b0);
    @(negedge clk); chk("sat_accept", bus.fetch_ready_o, 1); step();
    drive(1'b0, 64'h0, ADDI, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      chk("sat_stall", stall, (7 + k > 31) ? 31 : 7 + k);
      step();
    end
    flush = 1'b1;
    @(negedge clk); step();
    flush = 1'b0;
    @(negedge clk);
    chk("sat_flush_run", bus.fetch_ready_o, 1);
    chk("sat_flush_ivalid", bus.issue_valid_o, 0);
    chk("sat_after_flush", stall, 31);
    step();

    // Reset while in SERIAL discards the serializing entry and the counter.
    bus.sb_empty_i = 1'b1;
    drive(1'b1, 64'h4000, CSRRW, 1'b1, 1'b0);
    @(negedge clk); chk("rs_accept", bus.fetch_ready_o, 1); step();
    drive(1'b0, 64'h0, ADDI, 1'b0, 1'b0);
    @(negedge clk); chk("rs_drain", bus.issue_valid_o, 0); step();
    @(negedge clk);
    chk("rs_serial_ivalid", bus.issue_valid_o, 1);
    chk("rs_serial_pc", bus.issue_pc_o, 64'h4000);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rs_rst_ready", bus.fetch_ready_o, 0);
    chk("rs_rst_ivalid", bus.issue_valid_o, 0);
    step();
    reset = 1'b0;
    bus.issue_ready_i = 1'b1;
    @(negedge clk);
    chk("rs_ivalid", bus.issue_valid_o, 0);
    chk("rs_stall", stall, 0);
    chk("rs_run", bus.fetch_ready_o, 1);
    step();
    @(negedge clk); chk("rs_no_issue", bus.issue_valid_o, 0); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
